// File: rtl/open_list_queue_ctrl_if.sv
// Request/response and queue-strobe bundle for the open-list queue sequencer.
// The slave modport is the controller's view; master is the search-engine/queue side.
interface open_list_queue_ctrl_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  i_req_valid;
  logic                  o_req_ready;
  logic [1:0]            i_req_op;
  logic [DATA_WIDTH-1:0] i_req_data;
  logic                  o_rsp_valid;
  logic                  i_rsp_ready;
  logic [DATA_WIDTH-1:0] o_rsp_data;
  logic                  o_rsp_err;
  logic                  o_q_wrt;
  logic                  o_q_read;
  logic [DATA_WIDTH-1:0] o_q_node_f;
  logic                  i_q_full;
  logic                  i_q_empty;
  logic [DATA_WIDTH-1:0] i_q_node_f;

  modport slave (
    input  i_req_valid, i_req_op, i_req_data, i_rsp_ready,
    input  i_q_full, i_q_empty, i_q_node_f,
    output o_req_ready, o_rsp_valid, o_rsp_data, o_rsp_err,
    output o_q_wrt, o_q_read, o_q_node_f
  );

  modport master (
    output i_req_valid, i_req_op, i_req_data, i_rsp_ready,
    output i_q_full, i_q_empty, i_q_node_f,
    input  o_req_ready, o_rsp_valid, o_rsp_data, o_rsp_err,
    input  o_q_wrt, o_q_read, o_q_node_f
  );
endinterface

// File: rtl/open_list_queue_ctrl.sv
// Sequencer turning push/pop/replace requests into spaced strobes for the
// min-first open-list queue, with one response per request and status counters.
module open_list_queue_ctrl #(
  parameter int DATA_WIDTH    = 32,
  parameter int SETTLE_CYCLES = 3,
  parameter int CNT_WIDTH     = 16
) (
  input  logic                 CLK,
  input  logic                 RSTn,
  open_list_queue_ctrl_if.slave bus,
  output logic [CNT_WIDTH-1:0] o_op_cnt,
  output logic [CNT_WIDTH-1:0] o_err_cnt
);

  if (SETTLE_CYCLES < 2 || SETTLE_CYCLES > 15) begin : g_bad_settle
    $error("open_list_queue_ctrl: SETTLE_CYCLES must be within 2..15");
  end

  localparam logic [1:0] OP_PUSH = 2'b00;
  localparam logic [1:0] OP_POP  = 2'b01;
  localparam logic [1:0] OP_REPL = 2'b10;
  localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, SETTLE, RESP} state_t;

  state_t                state_q, state_d;
  logic                  ready_q, ready_d;
  logic                  wrt_q, wrt_d;
  logic                  read_q, read_d;
  logic [DATA_WIDTH-1:0] node_f_q, node_f_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic                  rsp_err_q, rsp_err_d;
  logic [DATA_WIDTH-1:0] removed_q, removed_d;
  logic                  is_push_q, is_push_d;
  logic [3:0]            settle_cnt_q, settle_cnt_d;
  logic [CNT_WIDTH-1:0]  op_cnt_q, op_cnt_d;
  logic [CNT_WIDTH-1:0]  err_cnt_q, err_cnt_d;
  logic                  accept;
  logic                  legal;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  always_comb begin
    state_d      = state_q;
    ready_d      = ready_q;
    wrt_d        = wrt_q;
    read_d       = read_q;
    node_f_d     = node_f_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_data_d   = rsp_data_q;
    rsp_err_d    = rsp_err_q;
    removed_d    = removed_q;
    is_push_d    = is_push_q;
    settle_cnt_d = settle_cnt_q;
    op_cnt_d     = op_cnt_q;
    err_cnt_d    = err_cnt_q;
    accept       = bus.i_req_valid & ready_q;

    // Replace on a full queue is fine: one node leaves as the other enters.
    case (bus.i_req_op)
      OP_PUSH: legal = ~bus.i_q_full;
      OP_POP:  legal = ~bus.i_q_empty;
      OP_REPL: legal = ~bus.i_q_empty;
      default: legal = 1'b0;
    endcase

    case (state_q)
      IDLE: begin
        if (accept) begin
          ready_d = 1'b0;
          if (legal) begin
            state_d   = ISSUE;
            wrt_d     = (bus.i_req_op == OP_PUSH) || (bus.i_req_op == OP_REPL);
            read_d    = (bus.i_req_op == OP_POP)  || (bus.i_req_op == OP_REPL);
            node_f_d  = bus.i_req_data;
            removed_d = bus.i_q_node_f;
            is_push_d = (bus.i_req_op == OP_PUSH);
          end else begin
            state_d     = RESP;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
            rsp_data_d  = '0;
            err_cnt_d   = sat_inc(err_cnt_q);
          end
        end
      end
      ISSUE: begin
        wrt_d        = 1'b0;
        read_d       = 1'b0;
        settle_cnt_d = SETTLE_LOAD;
        state_d      = SETTLE;
      end
      SETTLE: begin
        if (settle_cnt_q == 4'd0) begin
          // A push reports the settled head; pop/replace report the node removed at accept.
          state_d     = RESP;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b0;
          rsp_data_d  = is_push_q ? bus.i_q_node_f : removed_q;
          op_cnt_d    = sat_inc(op_cnt_q);
        end else begin
          settle_cnt_d = settle_cnt_q - 4'd1;
        end
      end
      RESP: begin
        if (bus.i_rsp_ready) begin
          rsp_valid_d = 1'b0;
          ready_d     = 1'b1;
          state_d     = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        ready_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_q      <= IDLE;
      ready_q      <= 1'b1;
      wrt_q        <= 1'b0;
      read_q       <= 1'b0;
      node_f_q     <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_data_q   <= '0;
      rsp_err_q    <= 1'b0;
      removed_q    <= '0;
      is_push_q    <= 1'b0;
      settle_cnt_q <= '0;
      op_cnt_q     <= '0;
      err_cnt_q    <= '0;
    end else begin
      state_q      <= state_d;
      ready_q      <= ready_d;
      wrt_q        <= wrt_d;
      read_q       <= read_d;
      node_f_q     <= node_f_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_data_q   <= rsp_data_d;
      rsp_err_q    <= rsp_err_d;
      removed_q    <= removed_d;
      is_push_q    <= is_push_d;
      settle_cnt_q <= settle_cnt_d;
      op_cnt_q     <= op_cnt_d;
      err_cnt_q    <= err_cnt_d;
    end
  end

  assign bus.o_req_ready = ready_q;
  assign bus.o_rsp_valid = rsp_valid_q;
  assign bus.o_rsp_data  = rsp_data_q;
  assign bus.o_rsp_err   = rsp_err_q;
  assign bus.o_q_wrt     = wrt_q;
  assign bus.o_q_read    = read_q;
  assign bus.o_q_node_f  = node_f_q;
  assign o_op_cnt        = op_cnt_q;
  assign o_err_cnt       = err_cnt_q;

endmodule

// File: tb/tb_open_list_queue_ctrl.sv
// Randomized bench for open_list_queue_ctrl against a sorted-queue model of the open list.
module tb_open_list_queue_ctrl;
  localparam int DW    = 32;
  localparam int SC    = 3;
  localparam int CW    = 4;
  localparam int DEPTH = 8;
  localparam int CMAX  = (1 << CW) - 1;

  logic CLK = 1'b0;
  logic RSTn;
  always #5 CLK = ~CLK;

  open_list_queue_ctrl_if #(.DATA_WIDTH(DW)) bus();
  logic [CW-1:0] op_cnt;
  logic [CW-1:0] err_cnt;

  open_list_queue_ctrl #(.DATA_WIDTH(DW), .SETTLE_CYCLES(SC), .CNT_WIDTH(CW)) dut (
    .CLK(CLK), .RSTn(RSTn), .bus(bus), .o_op_cnt(op_cnt), .o_err_cnt(err_cnt)
  );

  int nchk = 0;
  int nerr = 0;
  int exp_ops = 0;
  int exp_errs = 0;
  int unsigned qm[$];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Open-list queue: a sorted list, updated on strobes seen mid-cycle.
  always @(negedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      qm.delete();
    end else begin
      if (bus.o_q_read && qm.size() > 0) void'(qm.pop_front());
      if (bus.o_q_wrt) begin
        qm.push_back(bus.o_q_node_f);
        qm.sort();
      end
    end
    bus.i_q_empty  = (qm.size() == 0);
    bus.i_q_full   = (qm.size() >= DEPTH);
    bus.i_q_node_f = (qm.size() > 0) ? qm[0] : '0;
  end

  task automatic tick();
    @(posedge CLK);
    #2;
  endtask

  task automatic chk_reset_outputs();
    chk("rst_req_ready", bus.o_req_ready, 1);
    chk("rst_rsp_valid", bus.o_rsp_valid, 0);
    chk("rst_rsp_err",   bus.o_rsp_err, 0);
    chk("rst_rsp_data",  bus.o_rsp_data, 0);
    chk("rst_q_wrt",     bus.o_q_wrt, 0);
    chk("rst_q_read",    bus.o_q_read, 0);
    chk("rst_q_node_f",  bus.o_q_node_f, 0);
    chk("rst_op_cnt",    op_cnt, 0);
    chk("rst_err_cnt",   err_cnt, 0);
  endtask

  task automatic run_req(input logic [1:0] op, input int unsigned d, input int hold);
    int          wait_cyc;
    bit          legal;
    int          lat;
    int          size0;
    int unsigned head0;
    logic [DW-1:0] exp_data;
    logic        exp_w, exp_r;
    bus.i_req_valid = 1'b1;
    bus.i_req_op    = op;
    bus.i_req_data  = d;
    wait_cyc = 0;
    while (!bus.o_req_ready && wait_cyc < 50) begin
      tick();
      wait_cyc++;
    end
    if (!bus.o_req_ready) begin
      chk("accept_timeout", 0, 1);
      bus.i_req_valid = 1'b0;
      return;
    end
    size0 = qm.size();
    head0 = (size0 > 0) ? qm[0] : 0;
    if (op == 2'd0)                   legal = (size0 < DEPTH);
    else if (op == 2'd1 || op == 2'd2) legal = (size0 > 0);
    else                              legal = 1'b0;
    exp_w = legal && (op == 2'd0 || op == 2'd2);
    exp_r = legal && (op == 2'd1 || op == 2'd2);
    lat   = legal ? 2 + SC : 1;
    if (!legal)         exp_data = '0;
    else if (op == 2'd0) exp_data = (size0 > 0 && head0 < d) ? head0 : d;
    else                exp_data = head0;
    if (legal) exp_ops  = (exp_ops  < CMAX) ? exp_ops + 1  : CMAX;
    else       exp_errs = (exp_errs < CMAX) ? exp_errs + 1 : CMAX;

    for (int k = 1; k <= lat; k++) begin
      tick();
      chk("strobes", {bus.o_q_wrt, bus.o_q_read}, (k == 1) ? {exp_w, exp_r} : 2'b00);
      chk("req_ready_busy", bus.o_req_ready, 0);
      chk("rsp_valid_timing", bus.o_rsp_valid, (k == lat));
      if (k == 1 && legal) chk("q_node_f", bus.o_q_node_f, d);
    end
    chk("rsp_data", bus.o_rsp_data, exp_data);
    chk("rsp_err", bus.o_rsp_err, !legal);
    chk("op_cnt", op_cnt, exp_ops);
    chk("err_cnt", err_cnt, exp_errs);

    for (int j = 0; j < hold; j++) begin
      tick();
      chk("hold_valid", bus.o_rsp_valid, 1);
      chk("hold_data", bus.o_rsp_data, exp_data);
      chk("hold_err", bus.o_rsp_err, !legal);
      chk("hold_ready", bus.o_req_ready, 0);
      chk("hold_strobes", {bus.o_q_wrt, bus.o_q_read}, 2'b00);
    end

    bus.i_rsp_ready = 1'b1;
    tick();
    bus.i_rsp_ready = 1'b0;
    bus.i_req_valid = 1'b0;
    chk("rsp_valid_clear", bus.o_rsp_valid, 0);
    chk("ready_back", bus.o_req_ready, 1);
  endtask

  initial begin
    int guard;
    bus.i_req_valid = 1'b0;
    bus.i_req_op    = 2'd0;
    bus.i_req_data  = '0;
    bus.i_rsp_ready = 1'b0;
    RSTn = 1'b0;
    repeat (3) @(posedge CLK);
    #2;
    chk_reset_outputs();
    RSTn = 1'b1;
    tick();

    run_req(2'd0, 700, 0);
    run_req(2'd0, 300, 0);
    run_req(2'd0, 900, 1);
    run_req(2'd0, 100, 0);
    run_req(2'd1, 0, 0);
    run_req(2'd1, 0, 2);
    run_req(2'd1, 0, 0);

    guard = 0;
    while (qm.size() < DEPTH && guard < 20) begin
      run_req(2'd0, 200 + guard * 37, 0);
      guard++;
    end
    chk("filled", qm.size(), DEPTH);
    run_req(2'd0, 5, 0);
    run_req(2'd2, 5, 0);

    guard = 0;
    while (qm.size() > 0 && guard < 20) begin
      run_req(2'd1, 0, 0);
      guard++;
    end
    chk("drained", qm.size(), 0);
    run_req(2'd1, 0, 0);
    run_req(2'd2, 9, 0);
    run_req(2'd3, 11, 10);

    for (int i = 0; i < 80; i++) begin
      run_req(2'($urandom_range(0, 3)), $urandom_range(0, 1000), $urandom_range(0, 3));
    end

    // Reset in the ISSUE cycle of a push.
    bus.i_req_valid = 1'b1;
    bus.i_req_op    = 2'd0;
    bus.i_req_data  = 77;
    tick();
    bus.i_req_valid = 1'b0;
    chk("issue_wrt", bus.o_q_wrt, 1);
    #1;
    RSTn = 1'b0;
    #1;
    chk_reset_outputs();
    exp_ops  = 0;
    exp_errs = 0;
    @(posedge CLK);
    #2;
    RSTn = 1'b1;
    tick();
    chk("queue_reset", qm.size(), 0);
    run_req(2'd0, 42, 0);
    chk("post_reset_data", bus.o_rsp_data, 42);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
